pcie_tx_multilane: RTL
======================

Name: pcie_tx_multilane

Overview:
Parametrised multi-lane successor of the single-lane PCIE-interface transmitter. It accepts 8/16/32-bit parallel words with per-byte K flags through a valid/ready handshake and buffers bytes in a byte queue. It stripes bytes round-robin across LANES serial lanes, 8 bits per symbol, LSB first. It sits between the link-layer data source and the per-lane differential drivers. Lanes with no data available transmit the IDLE/COM symbol (8'hBC, K=1).

Parameters:
LANES, 2, number of serial lanes (1..4)
DEPTH, 8, byte-queue depth in entries of {K, byte}; must be >= max(4, LANES)
IDLE_SYM, 8'hBC, symbol sent when the queue cannot supply a full stripe

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  asynchronous, active-low reset
enb  input  1  global enable; 0 freezes all state
dataIn  input  32  parallel data; byte 0 = dataIn[7:0] is sent first
kIn  input  4  per-byte K flag; kIn[i] qualifies byte i
dataS  input  2  width select: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = reserved
valid  input  1  source presents a word
ready  output  1  block can accept the word of the selected width this cycle
serialOut  output  LANES  serial bit per lane
kOut  output  LANES  K flag of the symbol each lane is currently sending
symStart  output  1  high while bit 0 of a symbol is on serialOut

Behaviour:
- Reset (rst=0, asynchronous):
  - queue empty, count=0, bitCnt=0
  - each lane shift register loaded with IDLE_SYM; kOut = all ones
  - serialOut = IDLE_SYM[0] on every lane (0 for the default symbol); symStart = 1
  - ready reflects the combinational rule below.
- ready = enb && dataS != 11 && (DEPTH - count) >= nbytes(dataS). The rule uses the pre-edge count and does not credit a same-cycle pop.
- Accept: on a posedge with valid && ready, write nbytes entries {kIn[i], dataIn[8i+7:8i]}, i = 0..n-1, in order. Bytes above the selected width are ignored.
- dataS=11: ready=0 and nothing is accepted.
- bitCnt is a free-running 0..7 counter while enb=1. symStart = (bitCnt==0).
- Each cycle: serialOut[l] = shift[l][0]. On the edge where bitCnt != 7, each shift register shifts right by one.
- Load edge (bitCnt==7):
  - If the pre-edge count >= LANES: pop LANES entries; entry j goes to lane j (shift and kOut).
  - Otherwise: pop nothing; all lanes load IDLE_SYM with kOut=1. A stripe is never split.
- Simultaneous write and pop on one edge:
  - new count = count + n - LANES
  - bytes written on that edge are not eligible for that pop
  - queue order is preserved and there is no loss or duplication.
- Latency: a word accepted with an empty queue appears on the lanes at the first load edge after the write edge, provided it completes a stripe.
- Queue is circular with wrapping read/write pointers; count width = clog2(DEPTH+1). The queue can never overflow because of the ready rule.
- enb=0: bitCnt, shift registers, queue, kOut and serialOut all hold; ready=0.
- Reset mid-symbol: takes effect immediately and discards all queued bytes.

Test Plan:
- Reset (LANES=2): hold rst=0, then release → serialOut=00, kOut=11, symStart=1. Each lane then emits 0,0,1,1,1,1,0,1 per symbol (8'hBC) repeatedly; ready=1.
- 16-bit write dataIn=16'hABCD, dataS=01, kIn=0 → at the next load, lane0 sends 8'hCD and lane1 sends 8'hAB with kOut=00. The following symbol is IDLE on both lanes.
- Two 8-bit writes, 8'h25 then (after the next load edge) 8'h00 → the intervening symbol is IDLE (count=1 < 2). At the following load, lane0=8'h25 and lane1=8'h00.
- 32-bit write 32'h0123456F, dataS=10, kIn=4'b0001 → first symbol: lane0=8'h6F with K=1, lane1=8'h45. Second symbol: lane0=8'h23, lane1=8'h01, kOut=00.
- Back-to-back 32-bit writes with valid held high → ready deasserts whenever count > 4. The decoded lane stream equals the written byte sequence exactly. dataS=11 is never accepted.
- Mid-symbol events:
  - rst pulsed low → serialOut=00 immediately, queue flushed, only IDLE follows.
  - enb=0 for 5 cycles → serialOut and bitCnt frozen, ready=0. The symbol resumes intact once enb returns to 1.

Source files
------------

// File: rtl/pcie_tx_multilane_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_tx_multilane_if
//  Description : Word-input handshake and per-lane serial output bundle for
//                the multi-lane PCIe transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pcie_tx_multilane_if #(
  parameter int LANES = 2
);
  logic [31:0]      dataIn;
  logic [3:0]       kIn;
  logic [1:0]       dataS;
  logic             valid;
  logic             ready;
  logic [LANES-1:0] serialOut;
  logic [LANES-1:0] kOut;
  logic             symStart;

  // Source / observer side
  modport master (
    output dataIn, kIn, dataS, valid,
    input  ready, serialOut, kOut, symStart
  );

  // Transmitter side
  modport slave (
    input  dataIn, kIn, dataS, valid,
    output ready, serialOut, kOut, symStart
  );
endinterface
`default_nettype wire

// File: rtl/pcie_tx_multilane.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_tx_multilane
//  Description : Accepts 1/2/4-byte words with per-byte K flags into a circular
//                byte queue and stripes whole symbols round-robin across LANES
//                serial lanes, LSB first. Lanes send IDLE_SYM (K=1) whenever a
//                complete stripe is not available.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_tx_multilane #(
  parameter int         LANES    = 2,
  parameter int         DEPTH    = 8,
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  pcie_tx_multilane_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [8:0]       qMem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [CW-1:0]    count;
  logic [2:0]       bitCnt;
  logic [7:0]       shiftReg [LANES];
  logic [LANES-1:0] kReg;

  logic [2:0]       nBytes;
  logic             wrEn;
  logic             loadEdge;
  logic             popEn;

  // Circular pointer advance; inc never exceeds DEPTH so one wrap suffices
  function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] p, input int inc);
    int s;
    s = int'(p) + inc;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Byte count of the selected word width (reserved code accepts nothing)
  always_comb begin
    nBytes = 3'd0;
    case (bus.dataS)
      2'b00:   nBytes = 3'd1;
      2'b01:   nBytes = 3'd2;
      2'b10:   nBytes = 3'd4;
      default: nBytes = 3'd0;
    endcase
  end

  // Free space is judged on the pre-edge count; a same-edge pop is not credited
  assign bus.ready = enb && (bus.dataS != 2'b11) &&
                     ((DEPTH - int'(count)) >= int'(nBytes));
  assign wrEn      = bus.valid && bus.ready;
  assign loadEdge  = enb && (bitCnt == 3'd7);
  // A stripe is only popped whole; bytes written on this edge are not counted
  assign popEn     = loadEdge && (int'(count) >= LANES);

  // Queue storage; slots written are always free because of the ready rule
  always_ff @(posedge clk) begin
    if (rst && wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(nBytes)) begin
          qMem[ptrAdd(wrPtr, i)] <= {bus.kIn[i], bus.dataIn[8*i +: 8]};
        end
      end
    end
  end

  // Queue pointers and occupancy, with simultaneous write and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (enb) begin
      if (wrEn)  wrPtr <= ptrAdd(wrPtr, int'(nBytes));
      if (popEn) rdPtr <= ptrAdd(rdPtr, LANES);
      count <= CW'(int'(count) + (wrEn ? int'(nBytes) : 0) - (popEn ? LANES : 0));
    end
  end

  // Bit counter and per-lane shifters: shift 7 edges, reload on the 8th
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitCnt <= 3'd0;
      kReg   <= '1;
      for (int l = 0; l < LANES; l++) shiftReg[l] <= IDLE_SYM;
    end else if (enb) begin
      bitCnt <= bitCnt + 3'd1;
      for (int l = 0; l < LANES; l++) begin
        if (bitCnt == 3'd7) begin
          if (popEn) begin
            {kReg[l], shiftReg[l]} <= qMem[ptrAdd(rdPtr, l)];
          end else begin
            shiftReg[l] <= IDLE_SYM;
            kReg[l]     <= 1'b1;
          end
        end else begin
          shiftReg[l] <= {1'b0, shiftReg[l][7:1]};
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign bus.serialOut[l] = shiftReg[l][0];
    end
  endgenerate

  assign bus.kOut     = kReg;
  assign bus.symStart = (bitCnt == 3'd0);
endmodule
`default_nettype wire
